sync_fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO.
- Wraps a simple dual-port storage array with pointer, occupancy and flag logic.
- Adds a read-valid strobe, an occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Standard FIFO building block for single-clock datapaths in the design.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ram.sv | 37 +++
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: address-width derivation and
// parameter legality checks evaluated at elaboration.
package fifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull_th, input int aempty_th);
    return (width >= 1) && is_pow2(depth) && (depth >= 4) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read output register is reset; the array itself is not.
module sync_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // rdata holds its last value when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointer/occupancy control around sync_fifo_ram, with
// read-valid strobe, threshold flags and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   we,
  input  logic                   re,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] ONE_C    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);

  if (!params_ok(WIDTH, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            rvalid_q;
  logic            overflow_q;
  logic            underflow_q;
  logic            wr_ok;
  logic            rd_ok;
  logic [ADDR_W:0] ptr_diff;

  // Flags decode the registered count only, so they never follow we/re.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + ONE_C;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + ONE_C;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rvalid_q    <= rd_ok;
      overflow_q  <= we & full;
      underflow_q <= re & empty;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Wrap-bit pointers must always agree with the occupancy counter.
  assign ptr_diff = wptr_q - rptr_q;

  a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
    ptr_diff == count_q);

  assign count     = count_q;
  assign rvalid    = rvalid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed table-driven bench for sync_fifo_param (WIDTH=8, DEPTH=8,
// AFULL_TH=6, AEMPTY_TH=2) plus hand sequences for asynchronous reset.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] wd;
    int         cnt;
    logic       rv;
    logic [7:0] rd;
    logic       ov;
    logic       ud;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (6),
    .AEMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wdata        (wdata),
    .we           (we),
    .re           (re),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] wd,
                              input int cnt, input logic rv, input logic [7:0] rd,
                              input logic ov, input logic ud);
    vec_t v;
    v.we = w; v.re = r; v.wd = wd; v.cnt = cnt;
    v.rv = rv; v.rd = rd; v.ov = ov; v.ud = ud;
    return v;
  endfunction

  // {full, empty, almost_full, almost_empty} expected for a given occupancy
  function automatic logic [3:0] flags_for(input int cnt);
    return {cnt == 8, cnt == 0, cnt >= 6, cnt <= 2};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input int cnt, input logic rv,
                               input logic [7:0] rd, input logic ov, input logic ud);
    check("count", idx, 32'(count), 32'(cnt));
    check("flags", idx, 32'({full, empty, almost_full, almost_empty}), 32'(flags_for(cnt)));
    check("rvalid", idx, 32'(rvalid), 32'(rv));
    check("rdata", idx, 32'(rdata), 32'(rd));
    check("overflow", idx, 32'(overflow), 32'(ov));
    check("underflow", idx, 32'(underflow), 32'(ud));
  endtask

  // driver: present one vector, clock it, compare post-edge outputs
  task automatic apply(input vec_t v, input int idx);
    we    = v.we;
    re    = v.re;
    wdata = v.wd;
    @(posedge clk);
    #1;
    check_outputs(idx, v.cnt, v.rv, v.rd, v.ov, v.ud);
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;

    // 1: single write then read
    vecs.push_back(mk(1, 0, 8'hA5, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 0));
    // 2: fill, then a rejected write
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 8'(8'h10 + i), i + 1, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 0, 8'hFF, 8, 0, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8, 0, 8'hA5, 0, 0));
    // 3: drain in order, then a rejected read
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 8'h00, 7 - i, 1, 8'(8'h10 + i), 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h17, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h17, 0, 0));
    // 4: partial pass, then a full pass across the pointer wrap
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 8'(8'h30 + i), i + 1, 0, 8'h17, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 8'h00, 4 - i, 1, 8'(8'h30 + i), 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 8'(8'h20 + i), i + 1, 0, 8'h34, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 8'h00, 7 - i, 1, 8'(8'h20 + i), 0, 0));
    // 5a: simultaneous we&re at count 4
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 8'(8'h40 + i), i + 1, 0, 8'h27, 0, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 1, 8'(8'h50 + i), 4, 1, (i < 4) ? 8'(8'h40 + i) : 8'(8'h50 + i - 4), 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 8'h00, 3 - i, 1, 8'(8'h56 + i), 0, 0));
    // 5b: simultaneous we&re while full
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 8'(8'h60 + i), i + 1, 0, 8'h59, 0, 0));
    vecs.push_back(mk(1, 1, 8'hFF, 7, 1, 8'h60, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 7, 0, 8'h60, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 1, 8'h00, 6 - i, 1, 8'(8'h61 + i), 0, 0));
    // 5c: simultaneous we&re while empty: no bypass
    vecs.push_back(mk(1, 1, 8'h77, 1, 0, 8'h67, 0, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'h77, 0, 0));

    // reset state, checked while rst_n is still low
    #3;
    check_outputs(-1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    #19 rst_n = 1'b1;  // release between edges
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // 6: asynchronous reset with data in flight
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 8'(8'h90 + i), i + 1, 0, 8'h77, 0, 0), 1000 + i);
    apply(mk(0, 1, 8'h00, 4, 1, 8'h90, 0, 0), 1005);
    #2 rst_n = 1'b0;
    #1;
    check_outputs(2000, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    apply(mk(1, 0, 8'h3C, 1, 0, 8'h00, 0, 0), 2001);
    apply(mk(0, 1, 8'h00, 0, 1, 8'h3C, 0, 0), 2002);
    apply(mk(0, 0, 8'h00, 0, 0, 8'h3C, 0, 0), 2003);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
